// File: rtl/pong_ai_tracker.sv
// CPU opponent for the right paddle: tracks ball_y against the paddle centre with per-level
// reaction delay and start/stop hysteresis. Optional target jitter is enabled by AI_JITTER_EN.
module pong_ai_tracker #(
  parameter int WIDTH    = 10,
  parameter int PADDLE_H = 48,
  parameter int DW       = 8,
  parameter int DEAD0    = 75,
  parameter int DEAD1    = 55,
  parameter int DEAD2    = 35,
  parameter int DEAD3    = 24,
  parameter int GOOD0    = 35,
  parameter int GOOD1    = 25,
  parameter int GOOD2    = 15,
  parameter int GOOD3    = 8,
  parameter int DELAY0   = 6,
  parameter int DELAY1   = 4,
  parameter int DELAY2   = 2,
  parameter int DELAY3   = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             active,
  input  logic [1:0]       level_state,
  input  logic [WIDTH-1:0] ball_y,
  input  logic [WIDTH-1:0] paddle_y,
  input  logic             at_top,
  input  logic             at_bottom,
  output logic             move,
  output logic             up
);

  localparam int EW = WIDTH + 2;

  typedef enum logic [1:0] {STAY, WAIT, MOVE_UP, MOVE_DOWN} state_t;

  state_t               state_q, state_d;
  logic [DW-1:0]        cnt_q, cnt_d;
  logic                 dir_q, dir_d;
  logic signed [EW-1:0] off;
  logic signed [EW-1:0] centre, err, err_abs;
  logic signed [EW-1:0] dead_l, good_l;
  logic [DW-1:0]        delay_l;

  function automatic logic signed [EW-1:0] abs_err(input logic signed [EW-1:0] e);
    return (e < 0) ? -e : e;
  endfunction

  always_comb begin
    dead_l  = EW'(DEAD0);
    good_l  = EW'(GOOD0);
    delay_l = DW'(DELAY0);
    unique case (level_state)
      2'd1: begin dead_l = EW'(DEAD1); good_l = EW'(GOOD1); delay_l = DW'(DELAY1); end
      2'd2: begin dead_l = EW'(DEAD2); good_l = EW'(GOOD2); delay_l = DW'(DELAY2); end
      2'd3: begin dead_l = EW'(DEAD3); good_l = EW'(GOOD3); delay_l = DW'(DELAY3); end
      default: ;
    endcase
  end

  // Two guard bits keep paddle_y + PADDLE_H/2 + off and the subtraction free of wrap-around.
  always_comb begin
    centre  = $signed({2'b00, paddle_y}) + EW'(PADDLE_H / 2) + off;
    err     = $signed({2'b00, ball_y}) - centre;
    err_abs = abs_err(err);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    if (!active) begin
      state_d = STAY;
      cnt_d   = '0;
    end else if ((state_q == MOVE_UP && at_top) || (state_q == MOVE_DOWN && at_bottom)) begin
      state_d = STAY;
    end else if (tick) begin
      unique case (state_q)
        STAY: begin
          if (err_abs > dead_l) begin
            dir_d = err[EW-1];
            if (delay_l == '0) begin
              state_d = err[EW-1] ? MOVE_UP : MOVE_DOWN;
            end else begin
              state_d = WAIT;
              cnt_d   = delay_l;
            end
          end
        end
        WAIT: begin
          if (err_abs <= dead_l) begin
            state_d = STAY;
          end else if (cnt_q <= DW'(1)) begin
            state_d = dir_q ? MOVE_UP : MOVE_DOWN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - DW'(1);
          end
        end
        // No direct reversal: overshooting the band only ever returns to STAY.
        MOVE_UP:   if (err >= -good_l) state_d = STAY;
        MOVE_DOWN: if (err <= good_l)  state_d = STAY;
        default:   state_d = STAY;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= STAY;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

`ifdef AI_JITTER_EN
  logic [15:0]       lfsr_q, lfsr_d;
  logic signed [4:0] off_q, off_d;

  // Offset is latched when leaving STAY so one approach aims at a single target.
  always_comb begin
    lfsr_d = lfsr_q;
    off_d  = off_q;
    if (tick) lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    if (state_d == STAY) begin
      off_d = '0;
    end else if (state_q == STAY) begin
      off_d = $signed(lfsr_q[4:0]);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= 16'hACE1;
      off_q  <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      off_q  <= off_d;
    end
  end

  assign off = EW'(off_q);
`else
  assign off = '0;
`endif

  assign move = (state_q == MOVE_UP) || (state_q == MOVE_DOWN);
  assign up   = (state_q == MOVE_UP);

endmodule

// File: tb/tb_pong_ai_tracker.sv
// Self-checking bench for pong_ai_tracker (default build, no jitter): directed scenarios
// plus randomized stimulus checked against a behavioural integer model.
module tb_pong_ai_tracker;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       tick;
  logic       active;
  logic [1:0] level_state;
  logic [9:0] ball_y;
  logic [9:0] paddle_y;
  logic       at_top;
  logic       at_bottom;
  logic       move;
  logic       up;

  int tests = 0;
  int fails = 0;

  int DEAD_T[4]  = '{75, 55, 35, 24};
  int GOOD_T[4]  = '{35, 25, 15, 8};
  int DELAY_T[4] = '{6, 4, 2, 0};

  // Model: m_mov is the motion (-1 up, +1 down, 0 none); m_wait/m_left is the pending reaction.
  int m_mov, m_wait, m_left, m_pdir;

  pong_ai_tracker dut (
    .clock(clock), .reset_n(reset_n), .tick(tick), .active(active),
    .level_state(level_state), .ball_y(ball_y), .paddle_y(paddle_y),
    .at_top(at_top), .at_bottom(at_bottom), .move(move), .up(up)
  );

  always #5 clock = ~clock;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    m_mov = 0; m_wait = 0; m_left = 0; m_pdir = 0;
  endtask

  task automatic model_step();
    int e, ae, lv;
    lv = int'(level_state);
    e  = int'(ball_y) - (int'(paddle_y) + 24);
    ae = (e < 0) ? -e : e;
    if (!active) begin
      m_mov = 0; m_wait = 0; m_left = 0;
    end else if ((m_mov == -1 && at_top) || (m_mov == 1 && at_bottom)) begin
      m_mov = 0;
    end else if (tick) begin
      if (m_wait != 0) begin
        if (ae <= DEAD_T[lv]) m_wait = 0;
        else if (m_left <= 1) begin m_wait = 0; m_mov = m_pdir; end
        else m_left--;
      end else if (m_mov == -1) begin
        if (e >= -GOOD_T[lv]) m_mov = 0;
      end else if (m_mov == 1) begin
        if (e <= GOOD_T[lv]) m_mov = 0;
      end else if (ae > DEAD_T[lv]) begin
        m_pdir = (e < 0) ? -1 : 1;
        if (DELAY_T[lv] == 0) m_mov = m_pdir;
        else begin m_wait = 1; m_left = DELAY_T[lv]; end
      end
    end
  endtask

  task automatic cycle();
    if (reset_n) model_step(); else model_reset();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; tick = 1'b0; active = 1'b1; at_top = 1'b0; at_bottom = 1'b0;
    level_state = 2'd0; ball_y = 10'd0; paddle_y = 10'd0;
    model_reset();
    #3;
    @(posedge clock); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; tick = 1'b1; active = 1'b1; level_state = 2'd0;
    ball_y = 10'd500; paddle_y = 10'd0; at_top = 1'b0; at_bottom = 1'b0;
    model_reset();
    #2;
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests++;
      if (move !== 1'b0 || up !== 1'b0) begin
        fails++; $display("FAIL reset_hold: move=%0b up=%0b want 0 0", move, up);
      end
    end
    reset_n = 1'b1; tick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests++;
      if (move !== 1'b0) begin
        fails++; $display("FAIL reset_release_stay: move=%0b want 0", move);
      end
    end
    // ball far below: level 0 reaction, movement after the 7th tick
    tick = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      cycle();
      tests++;
      if (move !== (n == 7) || (n == 7 && up !== 1'b0)) begin
        fails++; $display("FAIL reset_then_track tick%0d: move=%0b up=%0b want move=%0b up=0", n, move, up, n == 7);
      end
    end
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if (move !== 1'b0 || up !== 1'b0) begin
      fails++; $display("FAIL async_reset_midop: move=%0b up=%0b want 0 0", move, up);
    end
    model_reset();
  endtask

  task automatic test_track_down();
    do_reset();
    level_state = 2'd3; paddle_y = 10'd200; ball_y = 10'd300; active = 1'b1; tick = 1'b1;
    cycle();
    tests++;
    if (move !== 1'b1 || up !== 1'b0) begin
      fails++; $display("FAIL track_first_tick: move=%0b up=%0b want 1 0", move, up);
    end
    for (int b = 299; b >= 225; b--) begin
      ball_y = 10'(b);
      cycle();
      tests++;
      if (move !== (b > 232) || up !== 1'b0) begin
        fails++; $display("FAIL track_stop ball=%0d: move=%0b up=%0b want %0b 0", b, move, up, b > 232);
      end
    end
  endtask

  task automatic test_delay_abort();
    do_reset();
    level_state = 2'd0; paddle_y = 10'd200; ball_y = 10'd100; tick = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      cycle();
      tests++;
      if (move !== (n >= 7) || up !== (n >= 7)) begin
        fails++; $display("FAIL delay_tick%0d: move=%0b up=%0b want %0b %0b", n, move, up, n >= 7, n >= 7);
      end
    end
    do_reset();
    level_state = 2'd0; paddle_y = 10'd200; ball_y = 10'd100; tick = 1'b1;
    repeat (3) cycle();
    ball_y = 10'd220;
    for (int n = 0; n < 10; n++) begin
      cycle();
      tests++;
      if (move !== 1'b0) begin
        fails++; $display("FAIL wait_abort cyc%0d: move=%0b want 0", n, move);
      end
    end
  endtask

  task automatic test_no_wrap();
    do_reset();
    level_state = 2'd3; paddle_y = 10'd0; ball_y = 10'd1000; tick = 1'b1;
    cycle();
    tests++;
    if (move !== 1'b1 || up !== 1'b0) begin
      fails++; $display("FAIL no_wrap_down: move=%0b up=%0b want 1 0", move, up);
    end
    do_reset();
    level_state = 2'd3; paddle_y = 10'd1000; ball_y = 10'd5; tick = 1'b1;
    cycle();
    tests++;
    if (move !== 1'b1 || up !== 1'b1) begin
      fails++; $display("FAIL no_wrap_up: move=%0b up=%0b want 1 1", move, up);
    end
  endtask

  task automatic test_limit_active();
    do_reset();
    level_state = 2'd3; paddle_y = 10'd1000; ball_y = 10'd5; tick = 1'b1;
    cycle();
    tick = 1'b0; ball_y = 10'd1020;
    cycle();
    tests++;
    if (move !== 1'b1 || up !== 1'b1) begin
      fails++; $display("FAIL hold_no_tick: move=%0b up=%0b want 1 1", move, up);
    end
    at_top = 1'b1;
    cycle();
    tests++;
    if (move !== 1'b0 || up !== 1'b0) begin
      fails++; $display("FAIL limit_top: move=%0b up=%0b want 0 0", move, up);
    end
    at_top = 1'b0;
    do_reset();
    level_state = 2'd3; paddle_y = 10'd0; ball_y = 10'd900; tick = 1'b1;
    cycle();
    tick = 1'b0; at_top = 1'b1;
    cycle();
    tests++;
    if (move !== 1'b1) begin
      fails++; $display("FAIL top_ignored_down: move=%0b want 1", move);
    end
    at_top = 1'b0; at_bottom = 1'b1;
    cycle();
    tests++;
    if (move !== 1'b0) begin
      fails++; $display("FAIL limit_bottom: move=%0b want 0", move);
    end
    at_bottom = 1'b0;
    do_reset();
    level_state = 2'd0; paddle_y = 10'd200; ball_y = 10'd100; tick = 1'b1;
    repeat (4) cycle();
    active = 1'b0;
    cycle();
    tests++;
    if (move !== 1'b0) begin
      fails++; $display("FAIL active_low: move=%0b want 0", move);
    end
    active = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      cycle();
      tests++;
      if (move !== (n == 7)) begin
        fails++; $display("FAIL active_restart tick%0d: move=%0b want %0b", n, move, n == 7);
      end
    end
  endtask

  task automatic test_level_change();
    do_reset();
    level_state = 2'd0; paddle_y = 10'd200; ball_y = 10'd100; tick = 1'b1;
    repeat (2) cycle();
    level_state = 2'd3;
    for (int n = 3; n <= 7; n++) begin
      cycle();
      tests++;
      if (move !== (n == 7)) begin
        fails++; $display("FAIL level_no_reload tick%0d: move=%0b want %0b", n, move, n == 7);
      end
    end
    do_reset();
    level_state = 2'd1; paddle_y = 10'd200; ball_y = 10'd160; tick = 1'b1;
    cycle();
    level_state = 2'd0;
    for (int n = 0; n < 8; n++) begin
      cycle();
      tests++;
      if (move !== 1'b0) begin
        fails++; $display("FAIL level_new_dead cyc%0d: move=%0b want 0", n, move);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    ball_y = 10'd512; paddle_y = 10'd300;
    for (int i = 0; i < 3000; i++) begin
      tick   = ($urandom_range(0, 2) == 0);
      active = ($urandom_range(0, 31) != 0);
      if ($urandom_range(0, 63) == 0) level_state = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0: ball_y = 10'($urandom_range(0, 1023));
        1: paddle_y = 10'($urandom_range(0, 1023));
        default: ball_y = ball_y + 10'($urandom_range(0, 6)) - 10'd3;
      endcase
      at_top    = ($urandom_range(0, 15) == 0);
      at_bottom = ($urandom_range(0, 15) == 0);
      cycle();
      tests++;
      if (move !== (m_mov != 0) || up !== (m_mov == -1)) begin
        fails++; $display("FAIL random cyc%0d: move=%0b up=%0b want %0b %0b", i, move, up, m_mov != 0, m_mov == -1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_track_down();
    test_delay_abort();
    test_no_wrap();
    test_limit_active();
    test_level_change();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
